// File: rtl/ps2_pkg.sv
// Shared types and frame check for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } ps2_state_e;

    // frame[0] = start, frame[8:1] = data LSB first, frame[9] = parity, frame[10] = stop
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead byte FIFO with registered head, flags and sticky overflow.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PS2_BYTE_W-1:0] wr_data,
    input  logic                  rd_en,
    output logic [PS2_BYTE_W-1:0] dout,
    output logic                  empty,
    output logic                  overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PS2_BYTE_W-1:0] mem_q [DEPTH];
    logic [PS2_BYTE_W-1:0] dout_q, dout_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  pop_c, push_c;

    always_comb begin
        pop_c      = rd_en && !empty_q;
        push_c     = wr_en && (!full_q || pop_c);
        wr_ptr_d   = wr_ptr_q + PW'(push_c);
        rd_ptr_d   = rd_ptr_q + PW'(pop_c);
        empty_d    = (wr_ptr_d == rd_ptr_d);
        full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        overflow_d = overflow_q;
        if (wr_en && full_q && !pop_c) begin
            overflow_d = 1'b1;
        end else if (pop_c) begin
            overflow_d = 1'b0;
        end
        // Next head may be the byte being written this very cycle.
        if (empty_d) begin
            dout_d = '0;
        end else if (push_c && (rd_ptr_d == wr_ptr_q)) begin
            dout_d = wr_data;
        end else begin
            dout_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign dout     = dout_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, framing FSM with timeout, byte FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [PS2_BYTE_W-1:0] data,
    output logic                  ready,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e                state_q, state_d;
    logic [2:0]                clk_sync_q, clk_sync_d;
    logic [1:0]                data_sync_q, data_sync_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]             to_cnt_q, to_cnt_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      frame_err_q, frame_err_d;
    logic                      fall_c, din_c, wr_en_c, rd_en_c;
    logic                      fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            frame_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            frame_q     <= frame_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        fall_c      = (clk_sync_q[2:1] == 2'b10);
        din_c       = data_sync_q[1];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        frame_d     = frame_q;
        frame_err_d = 1'b0;
        wr_en_c     = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (fall_c && !din_c) begin
                    // Start bit enters at the top and is shifted down to frame[0].
                    frame_d = {din_c, (PS2_FRAME_BITS - 1)'(0)};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_c) begin
                    frame_d   = {din_c, frame_q[PS2_FRAME_BITS-1:1]};
                    to_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'(1);
                    if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            CHECK: begin
                wr_en_c     = ps2_frame_ok(frame_q);
                frame_err_d = !ps2_frame_ok(frame_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_en_c = !nextdata_n && !fifo_empty;

    ps2_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_c),
        .wr_data  (frame_q[8:1]),
        .rd_en    (rd_en_c),
        .dout     (data),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ready     = !fifo_empty;
    assign frame_err = frame_err_q;

endmodule
